// File: rtl/kalman_predict_seq_if.sv
// Bundle interface between the measurement-update stage, kalman_predict_seq and the predicted-state bank.
// Handshake: a bundle crosses in_* (or out_*) on a rising edge where valid && ready; valid holds its data stable until then.
interface kalman_predict_seq_if #(
    parameter int AXES = 3,
    parameter int DW   = 16,
    parameter int OW   = 32
);
    logic               mode_diag;
    logic               in_valid;
    logic               in_ready;
    logic [AXES*DW-1:0] x_in;
    logic [AXES*DW-1:0] v_in;
    logic [AXES*DW-1:0] ppp_in;
    logic [AXES*DW-1:0] ppv_in;
    logic [AXES*DW-1:0] pvp_in;
    logic [AXES*DW-1:0] pvv_in;
    logic               out_valid;
    logic               out_ready;
    logic [AXES*OW-1:0] x_out;
    logic [AXES*OW-1:0] v_out;
    logic [AXES*OW-1:0] ppp_out;
    logic [AXES*OW-1:0] ppv_out;
    logic [AXES*OW-1:0] pvp_out;
    logic [AXES*OW-1:0] pvv_out;
    logic               sat;

    // master is the surrounding environment: it supplies bundles and consumes results.
    modport master (
        output mode_diag, in_valid, x_in, v_in, ppp_in, ppv_in, pvp_in, pvv_in, out_ready,
        input  in_ready, out_valid, x_out, v_out, ppp_out, ppv_out, pvp_out, pvv_out, sat
    );

    modport slave (
        input  mode_diag, in_valid, x_in, v_in, ppp_in, ppv_in, pvp_in, pvv_in, out_ready,
        output in_ready, out_valid, x_out, v_out, ppp_out, ppv_out, pvp_out, pvv_out, sat
    );
endinterface

// File: rtl/kalman_predict_seq.sv
// Constant-velocity Kalman predict stage: x' = F*x, P' = F*P*F^T + Q, one axis per clock
// through a shared datapath, with diagonal-only legacy mode and saturating outputs.
module kalman_predict_seq #(
    parameter int AXES     = 3,
    parameter int DW       = 16,
    parameter int OW       = 32,
    parameter int DT_SHIFT = 0,
    parameter int Q_POS    = 1,
    parameter int Q_VEL    = 10
) (
    input  logic                clk,
    input  logic                rst,
    kalman_predict_seq_if.slave bus
);
    localparam int IW   = DW + 2*DT_SHIFT + 4;
    // Q terms may be as wide as OW, so the accumulator covers both.
    localparam int CW   = ((IW > OW) ? IW : OW) + 2;
    localparam int IDXW = (AXES > 1) ? $clog2(AXES) : 1;
    localparam logic [IDXW-1:0]     LAST = IDXW'(AXES - 1);
    localparam logic signed [CW-1:0] QP   = CW'(Q_POS);
    localparam logic signed [CW-1:0] QV   = CW'(Q_VEL);
    localparam logic signed [CW-1:0] OMAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [CW-1:0] OMIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_n;
    logic [IDXW-1:0]    idx;
    logic               mode_r;
    logic               sat_r;
    logic               in_ready_c, out_valid_c;
    logic [AXES*DW-1:0] x_r, v_r, ppp_r, ppv_r, pvp_r, pvv_r;
    logic [AXES*OW-1:0] x_o, v_o, ppp_o, ppv_o, pvp_o, pvv_o;

    logic signed [CW-1:0] x_a, v_a, ppp_a, ppv_a, pvp_a, pvv_a;
    logic signed [CW-1:0] x_n, v_n, ppp_n, ppv_n, pvp_n, pvv_n;
    logic [OW:0]          x_c, v_c, ppp_c, ppv_c, pvp_c, pvv_c;
    logic                 step_sat;

    function automatic logic signed [CW-1:0] sx(input logic [DW-1:0] a);
        return CW'($signed(a));
    endfunction

    // Returns {clipped_flag, value}.
    function automatic logic [OW:0] clip(input logic signed [CW-1:0] a);
        if (a > OMAX)
            return {1'b1, OMAX[OW-1:0]};
        else if (a < OMIN)
            return {1'b1, OMIN[OW-1:0]};
        else
            return {1'b0, a[OW-1:0]};
    endfunction

    always_comb begin
        x_a   = sx(x_r[int'(idx)*DW +: DW]);
        v_a   = sx(v_r[int'(idx)*DW +: DW]);
        ppp_a = sx(ppp_r[int'(idx)*DW +: DW]);
        ppv_a = sx(ppv_r[int'(idx)*DW +: DW]);
        pvp_a = sx(pvp_r[int'(idx)*DW +: DW]);
        pvv_a = sx(pvv_r[int'(idx)*DW +: DW]);

        x_n   = x_a + (v_a <<< DT_SHIFT);
        v_n   = v_a;
        pvv_n = pvv_a + QV;
        if (mode_r) begin
            // Legacy predictor treats the cross term as 2*Ppv and leaves it unpropagated.
            ppp_n = ppp_a + (ppv_a <<< (1 + DT_SHIFT)) + (pvv_a <<< (2*DT_SHIFT)) + QP;
            ppv_n = ppv_a;
            pvp_n = pvp_a;
        end else begin
            ppp_n = ppp_a + ((ppv_a + pvp_a) <<< DT_SHIFT) + (pvv_a <<< (2*DT_SHIFT)) + QP;
            ppv_n = ppv_a + (pvv_a <<< DT_SHIFT);
            pvp_n = pvp_a + (pvv_a <<< DT_SHIFT);
        end

        x_c   = clip(x_n);
        v_c   = clip(v_n);
        ppp_c = clip(ppp_n);
        ppv_c = clip(ppv_n);
        pvp_c = clip(pvp_n);
        pvv_c = clip(pvv_n);
        step_sat = x_c[OW] | v_c[OW] | ppp_c[OW] | ppv_c[OW] | pvp_c[OW] | pvv_c[OW];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n     = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid)
                    state_n = CALC;
            end
            CALC: begin
                if (idx == LAST)
                    state_n = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            mode_r <= 1'b0;
            sat_r  <= 1'b0;
            x_r    <= '0;
            v_r    <= '0;
            ppp_r  <= '0;
            ppv_r  <= '0;
            pvp_r  <= '0;
            pvv_r  <= '0;
            x_o    <= '0;
            v_o    <= '0;
            ppp_o  <= '0;
            ppv_o  <= '0;
            pvp_o  <= '0;
            pvv_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mode_r <= bus.mode_diag;
                        x_r    <= bus.x_in;
                        v_r    <= bus.v_in;
                        ppp_r  <= bus.ppp_in;
                        ppv_r  <= bus.ppv_in;
                        pvp_r  <= bus.pvp_in;
                        pvv_r  <= bus.pvv_in;
                        sat_r  <= 1'b0;
                        idx    <= '0;
                    end
                end
                CALC: begin
                    x_o[int'(idx)*OW +: OW]   <= x_c[OW-1:0];
                    v_o[int'(idx)*OW +: OW]   <= v_c[OW-1:0];
                    ppp_o[int'(idx)*OW +: OW] <= ppp_c[OW-1:0];
                    ppv_o[int'(idx)*OW +: OW] <= ppv_c[OW-1:0];
                    pvp_o[int'(idx)*OW +: OW] <= pvp_c[OW-1:0];
                    pvv_o[int'(idx)*OW +: OW] <= pvv_c[OW-1:0];
                    sat_r <= sat_r | step_sat;
                    if (idx != LAST)
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sat       = sat_r;
    assign bus.x_out     = x_o;
    assign bus.v_out     = v_o;
    assign bus.ppp_out   = ppp_o;
    assign bus.ppv_out   = ppv_o;
    assign bus.pvp_out   = pvp_o;
    assign bus.pvv_out   = pvv_o;
endmodule

// File: tb/tb_kalman_predict_seq.sv
// Bench for kalman_predict_seq: two instances (default parameters, and DT_SHIFT=1/OW=18/AXES=2)
// checked every valid cycle against an arithmetic reference model, plus hand-computed pins.
module tb_kalman_predict_seq;
    localparam int BW = 640;
    localparam int QP = 1;
    localparam int QV = 10;

    typedef struct packed {
        logic [63:0] x, v, pp, pv, vp, vv;
        logic        s;
    } res_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [BW-1:0] exp_qa[$];
    logic [BW-1:0] exp_qb[$];
    logic [15:0]   stim[2][6][3];

    kalman_predict_seq_if #(.AXES(3), .DW(16), .OW(32)) ia();
    kalman_predict_seq_if #(.AXES(2), .DW(16), .OW(18)) ib();

    kalman_predict_seq #(.AXES(3), .DW(16), .OW(32), .DT_SHIFT(0), .Q_POS(QP), .Q_VEL(QV))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    kalman_predict_seq #(.AXES(2), .DW(16), .OW(18), .DT_SHIFT(1), .Q_POS(QP), .Q_VEL(QV))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_bits(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic signed [63:0] clip(input logic signed [63:0] a, input int ow, output logic c);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        c = (a > hi) || (a < lo);
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction

    function automatic res_t model(input logic signed [63:0] x, v, pp, pv, vp, vv,
                                   input int dts, input int ow, input logic diag);
        res_t r;
        logic signed [63:0] dt, px, pp2, pv2, vp2, vv2;
        logic c0, c1, c2, c3, c4, c5;
        dt  = 64'sd1 << dts;
        px  = x + v * dt;
        vv2 = vv + QV;
        if (diag) begin
            pp2 = pp + 2 * dt * pv + dt * dt * vv + QP;
            pv2 = pv;
            vp2 = vp;
        end else begin
            pp2 = pp + dt * (pv + vp) + dt * dt * vv + QP;
            pv2 = pv + dt * vv;
            vp2 = vp + dt * vv;
        end
        r.x  = clip(px, ow, c0);
        r.v  = clip(v, ow, c1);
        r.pp = clip(pp2, ow, c2);
        r.pv = clip(pv2, ow, c3);
        r.vp = clip(vp2, ow, c4);
        r.vv = clip(vv2, ow, c5);
        r.s  = c0 | c1 | c2 | c3 | c4 | c5;
        return r;
    endfunction

    function automatic logic signed [15:0] get_in(input bit b, input int sel, input int k);
        logic [47:0] bus;
        bus = '0;
        case (sel)
            0: bus = b ? 48'(ib.x_in)   : ia.x_in;
            1: bus = b ? 48'(ib.v_in)   : ia.v_in;
            2: bus = b ? 48'(ib.ppp_in) : ia.ppp_in;
            3: bus = b ? 48'(ib.ppv_in) : ia.ppv_in;
            4: bus = b ? 48'(ib.pvp_in) : ia.pvp_in;
            default: bus = b ? 48'(ib.pvv_in) : ia.pvv_in;
        endcase
        return bus[k*16 +: 16];
    endfunction

    // Layout matches {sat, x, v, ppp, ppv, pvp, pvv}, axis k at k*OW inside each field.
    function automatic logic [BW-1:0] expect_bundle(input bit b);
        int na, ow, dts;
        logic [BW-1:0] bun, mask;
        logic signed [63:0] fv[6];
        logic s;
        res_t r;
        na   = b ? 2 : 3;
        ow   = b ? 18 : 32;
        dts  = b ? 1 : 0;
        bun  = '0;
        s    = 1'b0;
        mask = (BW'(1) << ow) - BW'(1);
        for (int k = 0; k < na; k++) begin
            r = model(get_in(b, 0, k), get_in(b, 1, k), get_in(b, 2, k), get_in(b, 3, k),
                      get_in(b, 4, k), get_in(b, 5, k), dts, ow, b ? ib.mode_diag : ia.mode_diag);
            fv[0] = r.vv; fv[1] = r.vp; fv[2] = r.pv;
            fv[3] = r.pp; fv[4] = r.v;  fv[5] = r.x;
            s = s | r.s;
            for (int f = 0; f < 6; f++)
                bun = bun | ((BW'(fv[f]) & mask) << ((f*na + k) * ow));
        end
        bun[6*na*ow] = s;
        return bun;
    endfunction

    function automatic logic [BW-1:0] bundle(input bit b);
        if (b)
            return BW'({ib.sat, ib.x_out, ib.v_out, ib.ppp_out, ib.ppv_out, ib.pvp_out, ib.pvv_out});
        return BW'({ia.sat, ia.x_out, ia.v_out, ia.ppp_out, ia.ppv_out, ia.pvp_out, ia.pvv_out});
    endfunction

    function automatic logic out_valid_of(input bit b);
        return b ? ib.out_valid : ia.out_valid;
    endfunction

    function automatic logic in_ready_of(input bit b);
        return b ? ib.in_ready : ia.in_ready;
    endfunction

    // ---------------- compare process / scoreboard ----------------
    initial begin
        int  acc_cyc[2];
        logic ov_d[2];
        acc_cyc = '{0, 0};
        ov_d    = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_qa.delete();
                exp_qb.delete();
                ov_d = '{1'b0, 1'b0};
            end else begin
                for (int i = 0; i < 2; i++) begin
                    bit b;
                    int qs;
                    string nm;
                    b  = (i == 1);
                    nm = b ? "b" : "a";
                    qs = b ? exp_qb.size() : exp_qa.size();
                    if (out_valid_of(b)) begin
                        if (!ov_d[i])
                            chk($sformatf("latency_%s", nm), cyc - acc_cyc[i], b ? 2 : 3);
                        chk($sformatf("in_ready_in_done_%s", nm), in_ready_of(b), 0);
                        chk($sformatf("pending_%s", nm), qs, 1);
                        if (qs > 0) begin
                            chk_bits($sformatf("bundle_%s", nm), bundle(b), b ? exp_qb[0] : exp_qa[0]);
                            if (b ? ib.out_ready : ia.out_ready) begin
                                if (b) void'(exp_qb.pop_front());
                                else   void'(exp_qa.pop_front());
                            end
                        end
                    end
                    if ((b ? ib.in_valid : ia.in_valid) && in_ready_of(b)) begin
                        if (b) exp_qb.push_back(expect_bundle(1'b1));
                        else   exp_qa.push_back(expect_bundle(1'b0));
                        acc_cyc[i] = cyc + 1;
                    end
                    ov_d[i] = out_valid_of(b);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input bit b, input logic diag);
        if (b) begin
            ib.mode_diag = diag;
            for (int k = 0; k < 2; k++) begin
                ib.x_in[k*16 +: 16]   = stim[1][0][k];
                ib.v_in[k*16 +: 16]   = stim[1][1][k];
                ib.ppp_in[k*16 +: 16] = stim[1][2][k];
                ib.ppv_in[k*16 +: 16] = stim[1][3][k];
                ib.pvp_in[k*16 +: 16] = stim[1][4][k];
                ib.pvv_in[k*16 +: 16] = stim[1][5][k];
            end
        end else begin
            ia.mode_diag = diag;
            for (int k = 0; k < 3; k++) begin
                ia.x_in[k*16 +: 16]   = stim[0][0][k];
                ia.v_in[k*16 +: 16]   = stim[0][1][k];
                ia.ppp_in[k*16 +: 16] = stim[0][2][k];
                ia.ppv_in[k*16 +: 16] = stim[0][3][k];
                ia.pvp_in[k*16 +: 16] = stim[0][4][k];
                ia.pvv_in[k*16 +: 16] = stim[0][5][k];
            end
        end
    endtask

    task automatic set_axis(input bit b, input int k, input int x, v, pp, pv, vp, vv);
        stim[b][0][k] = 16'(x);
        stim[b][1][k] = 16'(v);
        stim[b][2][k] = 16'(pp);
        stim[b][3][k] = 16'(pv);
        stim[b][4][k] = 16'(vp);
        stim[b][5][k] = 16'(vv);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0: return 16'(int'($urandom_range(0, 16)) - 8);
            1: return $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_in(input bit b);
        for (int s = 0; s < 6; s++)
            for (int k = 0; k < 3; k++)
                stim[b][s][k] = rnd16();
        apply(b, 1'($urandom_range(0, 1)));
    endtask

    task automatic set_out_ready(input bit b, input logic v);
        if (b) ib.out_ready = v;
        else   ia.out_ready = v;
    endtask

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic send(input bit b);
        int n;
        if (b) ib.in_valid = 1'b1;
        else   ia.in_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready_of(b)) break;
        end
        chk("accept_ready", in_ready_of(b), 1);
        @(posedge clk);
        #1;
        if (b) ib.in_valid = 1'b0;
        else   ia.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit b);
        for (int n = 0; n < 50; n++) begin
            if (out_valid_of(b)) break;
            @(posedge clk);
            #1;
        end
        chk("valid_seen", out_valid_of(b), 1);
    endtask

    task automatic finish_bundle(input bit b, input int hold);
        set_out_ready(b, 1'b0);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        set_out_ready(b, 1'b1);
        @(posedge clk);
        #1;
        set_out_ready(b, 1'b0);
        chk("valid_drop", out_valid_of(b), 0);
    endtask

    task automatic lit(input string name, input bit b, input int k,
                       input int ex, ev, epp, epv, evp, evv, input int es);
        logic [BW-1:0] bun, tmp;
        logic signed [63:0] val[6];
        int na, ow;
        int exp_v[6];
        string fn[6];
        bun = bundle(b);
        na  = b ? 2 : 3;
        ow  = b ? 18 : 32;
        exp_v = '{evv, evp, epv, epp, ev, ex};
        fn    = '{"pvv", "pvp", "ppv", "ppp", "v", "x"};
        for (int f = 0; f < 6; f++) begin
            tmp    = bun >> ((f*na + k) * ow);
            val[f] = tmp[63:0];
            val[f] = val[f] <<< (64 - ow);
            val[f] = val[f] >>> (64 - ow);
            chk($sformatf("%s_%s", name, fn[f]), val[f], exp_v[f]);
        end
        chk($sformatf("%s_sat", name), bun[6*na*ow], es);
    endtask

    task automatic check_reset_state(input bit b);
        chk("rst_out_valid", out_valid_of(b), 0);
        chk("rst_in_ready", in_ready_of(b), 1);
        chk("rst_sat", b ? ib.sat : ia.sat, 0);
        chk_bits("rst_outputs", bundle(b), '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        res_t r;
        rst = 1'b1;
        ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.mode_diag = 1'b0;
        ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.mode_diag = 1'b0;
        ia.x_in = '0; ia.v_in = '0; ia.ppp_in = '0; ia.ppv_in = '0; ia.pvp_in = '0; ia.pvv_in = '0;
        ib.x_in = '0; ib.v_in = '0; ib.ppp_in = '0; ib.ppv_in = '0; ib.pvp_in = '0; ib.pvv_in = '0;

        // Pin the model with hand-derived values.
        r = model(100, 5, 50, 3, 3, 4, 0, 32, 1'b0);
        chk("model_full_ppp", r.pp, 61);
        chk("model_full_ppv", r.pv, 7);
        r = model(100, 5, 50, 3, 3, 4, 0, 32, 1'b1);
        chk("model_diag_ppv", r.pv, 3);
        r = model(-20, -7, 10, 1, 2, 3, 1, 18, 1'b0);
        chk("model_dt_x", r.x, -34);
        chk("model_dt_ppp", r.pp, 29);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state(1'b0);
        check_reset_state(1'b1);

        // Default bundle, full then diagonal mode.
        for (int k = 0; k < 3; k++) set_axis(0, k, 100, 5, 50, 3, 3, 4);
        apply(0, 1'b0);
        send(0);
        wait_valid(0);
        for (int k = 0; k < 3; k++) lit($sformatf("full_ax%0d", k), 0, k, 105, 5, 61, 7, 7, 14, 0);
        finish_bundle(0, 2);

        apply(0, 1'b1);
        send(0);
        wait_valid(0);
        for (int k = 0; k < 3; k++) lit($sformatf("diag_ax%0d", k), 0, k, 105, 5, 61, 3, 3, 14, 0);
        finish_bundle(0, 0);

        // dt = 2 on the narrow instance.
        set_axis(1, 0, -20, -7, 10, 1, 2, 3);
        set_axis(1, 1, 7, 1, 2, 0, 0, 1);
        apply(1, 1'b0);
        send(1);
        wait_valid(1);
        lit("dt2", 1, 0, -34, -7, 29, 7, 8, 13, 0);
        finish_bundle(1, 1);

        // Saturation at OW=18.
        for (int k = 0; k < 2; k++) set_axis(1, k, 0, 0, 32767, 32767, 32767, 32767);
        apply(1, 1'b0);
        send(1);
        wait_valid(1);
        lit("satur", 1, 0, 0, 0, 131071, 98301, 98301, 32777, 1);
        finish_bundle(1, 0);

        // Back-pressure with in_valid held high and upstream data changing meanwhile.
        rand_in(0);
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        wait_valid(0);
        rand_in(0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", ia.in_ready, 0);
            chk("hold_out_valid", ia.out_valid, 1);
        end
        ia.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ia.out_ready = 1'b0;
        chk("release_out_valid", ia.out_valid, 0);
        chk("release_in_ready", ia.in_ready, 1);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        chk("next_accepted", ia.in_ready, 0);
        wait_valid(0);
        finish_bundle(0, 1);

        // Reset mid-calculation (idx = 1), then a clean transaction.
        for (int k = 0; k < 3; k++) set_axis(0, k, 100, 5, 50, 3, 3, 4);
        apply(0, 1'b0);
        send(0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state(1'b0);
        send(0);
        wait_valid(0);
        lit("post_rst", 0, 2, 105, 5, 61, 7, 7, 14, 0);
        finish_bundle(0, 0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            rand_in(b);
            set_out_ready(b, 1'($urandom_range(0, 1)));
            send(b);
            wait_valid(b);
            finish_bundle(b, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("leftover_a", exp_qa.size(), 0);
        chk("leftover_b", exp_qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/kalman_predict_seq.md
Name: kalman_predict_seq

Overview:
Sequential, parametrised successor to the combinational constant-velocity predict stage of the Kalman tracker. It computes x' = F·x and P' = F·P·Fᵀ + Q for AXES decoupled position/velocity axes, one axis per clock, using a shared arithmetic datapath. It supports full 2x2 per-axis covariance propagation or a legacy diagonal-only mode, a power-of-two time step, and output saturation. It sits between the measurement-update stage and the predicted-state register bank, connected by valid/ready handshakes on both sides.

Parameters:
AXES, 3, number of independent axes (1..8)
DW, 16, signed input width of each state and covariance element
OW, 32, signed output width (OW >= DW+1)
DT_SHIFT, 0, time step dt = 2^DT_SHIFT (0..3)
Q_POS, 1, process noise added to Ppp (signed, fits in OW)
Q_VEL, 10, process noise added to Pvv (signed, fits in OW)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
mode_diag  in  1  1 = legacy diagonal-only update, 0 = full 2x2 update; sampled on acceptance
in_valid  in  1  input bundle valid
in_ready  out  1  block can accept a bundle
x_in  in  AXES*DW  positions; axis k occupies bits [k*DW +: DW]
v_in  in  AXES*DW  velocities
ppp_in, ppv_in, pvp_in, pvv_in  in  AXES*DW each  per-axis covariance block (pos-pos, pos-vel, vel-pos, vel-vel)
out_valid  out  1  result bundle valid
out_ready  in  1  downstream accepts the result
x_out, v_out  out  AXES*OW each  predicted state
ppp_out, ppv_out, pvp_out, pvv_out  out  AXES*OW each  predicted covariance
sat  out  1  at least one output element in the current bundle saturated

Behaviour:
- FSM states: IDLE, CALC, DONE. Axis index register idx has width clog2(AXES), minimum 1 bit.
- IDLE: in_ready=1. When in_valid=1, the block captures all inputs and mode_diag, clears sat, sets idx=0 and moves to CALC.
- CALC: in_ready=0. Each cycle the block computes axis idx and writes its output slices. When idx=AXES-1 it moves to DONE; otherwise idx increments.
- DONE: out_valid=1. All outputs are held stable until out_ready=1; on that edge out_valid drops and the FSM returns to IDLE. in_ready stays 0 in DONE, so no skid and no overlap.
- Latency: out_valid goes high exactly AXES cycles after the acceptance edge. Minimum spacing between accepted bundles is AXES+2 cycles.
- Inputs are sign-extended. Arithmetic uses internal width DW+2*DT_SHIFT+4, which is exact with no intermediate overflow. Multiplication by dt is a left shift by DT_SHIFT (arithmetic).
- x' = x + (v<<<DT_SHIFT); v' = v.
- Full mode:
  - Ppp' = Ppp + ((Ppv+Pvp)<<<DT_SHIFT) + (Pvv<<<2*DT_SHIFT) + Q_POS
  - Ppv' = Ppv + (Pvv<<<DT_SHIFT)
  - Pvp' = Pvp + (Pvv<<<DT_SHIFT)
  - Pvv' = Pvv + Q_VEL
- Diag mode:
  - Ppp' = Ppp + (Ppv<<<(1+DT_SHIFT)) + (Pvv<<<2*DT_SHIFT) + Q_POS
  - Pvv' = Pvv + Q_VEL
  - Ppv and Pvp pass through unchanged (sign-extended).
- Every result is saturated to the signed OW range [-2^(OW-1), 2^(OW-1)-1]. Any clipping sets sat, which stays sticky until the next acceptance.
- Reset: FSM goes to IDLE, idx=0, in_ready=1 on the first cycle after reset, out_valid=0, sat=0, and all data outputs=0.
- Reset asserted in CALC or DONE aborts the transaction and no output is delivered. Reset has priority over every handshake.
- in_valid asserted during CALC or DONE is ignored; the upstream stage holds its data until in_ready=1.
- out_ready=1 while out_valid=0 has no effect.
- Output slices for axes not yet computed keep their previous bundle's values until overwritten. Downstream reads only while out_valid=1.

Test Plan:
- Defaults, mode_diag=0, every axis: x=100, v=5, Ppp=50, Ppv=3, Pvp=3, Pvv=4; pulse in_valid 1 cycle. Required: out_valid rises exactly 3 cycles after the acceptance edge with x'=105, v'=5, Ppp'=61, Ppv'=7, Pvp'=7, Pvv'=14, sat=0.
- Same inputs with mode_diag=1. Required: Ppp'=61, Ppv'=3, Pvp'=3, Pvv'=14, matching the legacy diagonal predictor.
- DT_SHIFT=1, axis 0: x=-20, v=-7, Ppp=10, Ppv=1, Pvp=2, Pvv=3, full mode. Required: x'=-34, Ppp'=10+6+12+1=29, Ppv'=7, Pvp'=8, Pvv'=13.
- OW=18, DT_SHIFT=1, all covariance inputs=32767, full mode. Required: Ppp'=131071 (saturated), sat=1, Pvv'=32777.
- Hold out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 throughout. Required: outputs stable, in_ready=0, no new capture. Then set out_ready=1: out_valid drops next cycle, in_ready=1, and the next bundle is accepted.
- Assert rst for 1 cycle while idx=1 in CALC. Required: next cycle out_valid=0, in_ready=1, sat=0, all outputs 0, and a subsequent transaction completes with correct values.
